zigzag_scanner: RTL and testbench

Sequential scan controller that reads an 8x8 matrix from the combinational matrix ROM in JPEG zig-zag order and emits it as a 64-beat valid/ready stream. It sits directly upstream of the ROM's address port and downstream of its data port. It converts the ROM's row-major storage into a zig-zag-ordered stream for the next stage.

---
 rtl/zigzag_pkg.sv | 14 +
 rtl/zigzag_pos_step.sv | 45 ++++
 rtl/zigzag_scanner.sv | 137 +++++++++++++
 tb/tb_zigzag_scanner.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zigzag_pkg.sv
// Shared defaults and the scan FSM state type for the zig-zag scanner.
package zigzag_pkg;

   localparam int DEF_DIM    = 8;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 2 * $clog2(DEF_DIM);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN
   } scan_state_t;

endpackage : zigzag_pkg

// File: rtl/zigzag_pos_step.sv
// Combinational zig-zag traversal step: (row, col) -> next (row, col).
// Even diagonals (row+col even) move up-right, odd diagonals move down-left.
module zigzag_pos_step #(
   parameter  int DIM   = 8,
   localparam int POS_W = $clog2(DIM)
) (
   input  logic [POS_W-1:0] i_row,
   input  logic [POS_W-1:0] i_col,
   output logic [POS_W-1:0] o_next_row,
   output logic [POS_W-1:0] o_next_col
);

   localparam logic [POS_W-1:0] POS_MAX = POS_W'(DIM - 1);

   logic w_even;

   assign w_even = (i_row[0] == i_col[0]);

   // Select the next matrix position from the diagonal direction and edges.
   always_comb begin
      // NOTE: both outputs get a default first so no path leaves them unassigned (no latch).
      o_next_row = i_row;
      o_next_col = i_col;
      if (w_even) begin
         if (i_col == POS_MAX) begin
            o_next_row = i_row + 1'b1;
         end else if (i_row == '0) begin
            o_next_col = i_col + 1'b1;
         end else begin
            o_next_row = i_row - 1'b1;
            o_next_col = i_col + 1'b1;
         end
      end else begin
         if (i_row == POS_MAX) begin
            o_next_col = i_col + 1'b1;
         end else if (i_col == '0) begin
            o_next_row = i_row + 1'b1;
         end else begin
            o_next_row = i_row + 1'b1;
            o_next_col = i_col - 1'b1;
         end
      end
   end

endmodule : zigzag_pos_step

// File: rtl/zigzag_scanner.sv
// Zig-zag scan controller: walks an 8x8 ROM in JPEG zig-zag order and
// emits the elements as a 64-beat valid/ready stream.
module zigzag_scanner
   import zigzag_pkg::*;
#(
   parameter  int DATA_W = DEF_DATA_W,
   parameter  int DIM    = DEF_DIM,
   localparam int POS_W  = $clog2(DIM),
   localparam int ADDR_W = 2 * POS_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_last,
   output logic              done
);

   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DIM * DIM - 1);

   scan_state_t       r_state;
   scan_state_t       w_state_next;

   logic [POS_W-1:0]  r_row;
   logic [POS_W-1:0]  r_col;
   logic [ADDR_W-1:0] r_idx;
   logic [POS_W-1:0]  w_next_row;
   logic [POS_W-1:0]  w_next_col;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [ADDR_W-1:0] r_out_index;
   logic              r_out_last;
   logic              r_done;

   logic              w_load;
   logic              w_idx_last;
   logic              w_accept;
   logic              w_handshake;
   logic              w_last_hs;

   assign w_accept    = (r_state == IDLE) && start;
   assign w_load      = (r_state == SCAN) && (!r_out_valid || out_ready);
   assign w_idx_last  = (r_idx == IDX_LAST);
   assign w_handshake = r_out_valid && out_ready;
   assign w_last_hs   = w_handshake && r_out_last;

   zigzag_pos_step #(
      .DIM        (DIM)
   ) u_pos_step (
      .i_row      (r_row),
      .i_col      (r_col),
      .o_next_row (w_next_row),
      .o_next_col (w_next_col)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
         r_state <= w_state_next;
      end
   end

   // FSM next-state logic: start only matters in IDLE; DRAIN waits for the last handshake.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start)                 w_state_next = SCAN;
         SCAN:    if (w_load && w_idx_last)  w_state_next = DRAIN;
         DRAIN:   if (w_last_hs)             w_state_next = IDLE;
         default:                            w_state_next = IDLE;
      endcase
   end

   // Scan position and zig-zag index; advance on each output load, hold after the final one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row <= '0;
         r_col <= '0;
         r_idx <= '0;
      end else if (w_accept) begin
         r_row <= '0;
         r_col <= '0;
         r_idx <= '0;
      end else if (w_load && !w_idx_last) begin
         r_row <= w_next_row;
         r_col <= w_next_col;
         r_idx <= r_idx + 1'b1;
      end
   end

   // Output register: load a new beat when empty or draining, clear valid on a bare handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the data/index registers are reset too, since their reset values are observable outputs.
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_index <= '0;
         r_out_last  <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= rom_data;
         r_out_index <= r_idx;
         r_out_last  <= w_idx_last;
      end else if (w_handshake) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end
   end

   // One-cycle completion pulse after the last beat is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= 1'b0;
      end else begin
         r_done <= w_last_hs;
      end
   end

   assign busy      = (r_state != IDLE);
   assign rom_addr  = {r_row, r_col};
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_index = r_out_index;
   assign out_last  = r_out_last;
   assign done      = r_done;

endmodule : zigzag_scanner

// File: tb/tb_zigzag_scanner.sv
// Directed self-checking bench for zigzag_scanner with an identity ROM.
module tb_zigzag_scanner;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       busy;
   logic [5:0] rom_addr;
   logic [7:0] rom_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [5:0] out_index;
   logic       out_last;
   logic       done;

   int total = 0;
   int bad   = 0;

   // JPEG zig-zag order: row-major address of each zig-zag index.
   int zz [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };

   // Identity ROM: each location holds its own address.
   assign rom_data = {2'b00, rom_addr};

   zigzag_scanner #(
      .DATA_W    (8),
      .DIM       (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Pulse start, then check 64 back-to-back beats and the done pulse.
   // Returns at the done cycle's falling edge. poke re-pulses start during the scan.
   task automatic full_scan(input bit poke);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("valid_before_first", 32'(out_valid), 32'd0);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (poke) start = (i % 3 == 0);
         check("beat_valid", 32'(out_valid), 32'd1);
         check("beat_data", 32'(out_data), 32'(zz[i]));
         check("beat_index", 32'(out_index), 32'(i));
         check("beat_last", 32'(out_last), 32'(i == 63));
         if (i == 63) begin
            check("busy_on_last", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
         end
      end
      @(negedge clk);
      start = 1'b0;
      check("done_pulse", 32'(done), 32'd1);
      check("busy_fall", 32'(busy), 32'd0);
      check("valid_after_last", 32'(out_valid), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic       prev_stall;
      logic [7:0] prev_data;
      logic [5:0] prev_index;
      logic       prev_last;
      logic [5:0] prev_addr;
      int         cnt;
      int         done_cnt;
      int         done_cyc;
      int         hs_cyc;

      rst_n     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      #1;
      // Reset state.
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_index", 32'(out_index), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_addr", 32'(rom_addr), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Full-throughput scan.
      full_scan(1'b0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);

      // start pulsed repeatedly while busy is ignored.
      full_scan(1'b1);
      @(negedge clk);
      check("poke_done_one_cycle", 32'(done), 32'd0);
      check("poke_idle", 32'(busy), 32'd0);

      // Random backpressure with a scoreboard on order and stability.
      out_ready  = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt        = 0;
      done_cnt   = 0;
      done_cyc   = -1;
      hs_cyc     = -100;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_index = '0;
      prev_last  = 1'b0;
      prev_addr  = '0;
      for (int cyc = 0; cyc < 2000 && done_cnt == 0; cyc++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(prev_data));
            check("stall_index", 32'(out_index), 32'(prev_index));
            check("stall_last", 32'(out_last), 32'(prev_last));
            check("stall_addr", 32'(rom_addr), 32'(prev_addr));
         end
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            if (cnt < 64) begin
               check("rnd_data", 32'(out_data), 32'(zz[cnt]));
               check("rnd_index", 32'(out_index), 32'(cnt));
               check("rnd_last", 32'(out_last), 32'(cnt == 63));
               if (cnt == 63) hs_cyc = cyc;
            end else begin
               check("rnd_extra_beat", 32'(cnt), 32'd63);
            end
            cnt++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_index = out_index;
         prev_last  = out_last;
         prev_addr  = rom_addr;
      end
      out_ready = 1'b1;
      check("rnd_handshakes", 32'(cnt), 32'd64);
      check("rnd_done_count", 32'(done_cnt), 32'd1);
      check("rnd_done_timing", 32'(done_cyc), 32'(hs_cyc + 1));
      @(negedge clk);
      check("rnd_done_clear", 32'(done), 32'd0);
      check("rnd_idle", 32'(busy), 32'd0);

      // Last beat stalled for 5 cycles.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (i == 63) begin
            check("stall5_arrive_data", 32'(out_data), 32'd63);
            check("stall5_arrive_last", 32'(out_last), 32'd1);
            out_ready = 1'b0;
         end
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall5_valid", 32'(out_valid), 32'd1);
         check("stall5_last", 32'(out_last), 32'd1);
         check("stall5_data", 32'(out_data), 32'd63);
         check("stall5_index", 32'(out_index), 32'd63);
         check("stall5_no_done", 32'(done), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("stall5_done", 32'(done), 32'd1);
      check("stall5_valid_clr", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("stall5_done_once", 32'(done), 32'd0);

      // start in the done cycle is accepted.
      full_scan(1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_busy", 32'(busy), 32'd1);
      check("restart_no_beat", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("restart_valid", 32'(out_valid), 32'd1);
      check("restart_index", 32'(out_index), 32'd0);
      check("restart_data", 32'(out_data), 32'd0);
      do_reset();

      // Reset dropped mid-scan at beat 20.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (21) @(negedge clk);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      check("pre_rst_index", 32'(out_index), 32'd20);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_index", 32'(out_index), 32'd0);
      check("midrst_data", 32'(out_data), 32'd0);
      check("midrst_addr", 32'(rom_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("fresh_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("fresh_valid", 32'(out_valid), 32'd1);
      check("fresh_index", 32'(out_index), 32'd0);
      check("fresh_data", 32'(out_data), 32'd0);
      @(negedge clk);
      check("fresh_second", 32'(out_data), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_zigzag_scanner
